ofmap_pingpong_buf: RTL and testbench
=====================================

OFMAP_PINGPONG_BUF -- requirements
Module: ofmap_pingpong_buf

Interface
REQ-001 SHALL have parameter DW, default 8, data element width.
REQ-002 SHALL have parameter CH, default 6, number of output channels.
REQ-003 SHALL have parameter LINES, default 32, x positions (line RAMs) per channel.
REQ-004 SHALL have parameter DEPTH, default 32, y entries per line.
REQ-005 SHALL have parameters COLS, default 8, write lanes, and ROWS, default 8, read lanes.
REQ-006 SHALL have parameter ADDR_DW, default 5, x/y address width; 2^ADDR_DW >= max(LINES, DEPTH).
REQ-007 SHALL have ports clk (in, 1, the single clock) and rst (in, 1, asynchronous active-high reset).
REQ-008 SHALL have STRIDE (in, 2), KERNEL_DIM (in, 4) and INFMAP_ROWS (in, 6): window geometry, quasi-static.
REQ-009 SHALL have wr_valid (in, 1), wr_ready (out, 1), wr_ch_base (in, 4), wr_x (in, ADDR_DW), wr_y (in, ADDR_DW) and wr_data (in, DW*COLS; lane k at bits k*DW).
REQ-010 SHALL have wr_frame_done (in, 1): the write bank is complete.
REQ-011 SHALL have rd_req (in, 1), rd_req_ready (out, 1), rd_ch (in, 4), rd_x_base (in, ADDR_DW), rd_x_off (in, 8) and rd_y (in, ADDR_DW).
REQ-012 SHALL have rd_data (out, DW*ROWS; lane j at bits j*DW) and rd_data_valid (out, 1).
REQ-013 SHALL have rd_frame_done (in, 1): the read bank is consumed.
REQ-014 SHALL have bank_full (out, 2), err_wr (out, 1) and err_rd (out, 1), both error flags sticky.

Function
REQ-015 SHALL hold two banks, each CH x LINES x DEPTH x DW, with per-bank state EMPTY/FULL, a write pointer wsel and a read pointer rsel.
REQ-016 SHALL drive wr_ready = (bank[wsel]==EMPTY) and rd_req_ready = (bank[rsel]==FULL), both combinationally from registered state.
REQ-017 On wr_valid&&wr_ready, SHALL write lane k into bank wsel, channel wr_ch_base+k, line wr_x, entry wr_y for each k < COLS with wr_ch_base+k < CH; lanes with wr_ch_base+k >= CH are dropped silently.
REQ-018 wr_valid while !wr_ready SHALL write nothing and set err_wr.
REQ-019 wr_frame_done while bank[wsel]==EMPTY SHALL set bank[wsel]=FULL and toggle wsel; otherwise it SHALL be ignored and SHALL set err_wr.
REQ-020 rd_frame_done while bank[rsel]==FULL SHALL set bank[rsel]=EMPTY and toggle rsel; otherwise it SHALL be ignored and SHALL set err_rd.
REQ-021 Both done events in one cycle SHALL both take effect; a write in the same cycle as wr_frame_done SHALL land in the old bank.
REQ-022 Effective stride s SHALL be STRIDE, with 0 treated as 1; xlim SHALL equal INFMAP_ROWS-KERNEL_DIM, or 0 if that is negative; all index arithmetic SHALL be at least 10 bits with no truncation.
REQ-023 On rd_req&&rd_req_ready, for j in 0..ROWS-1: base position p = rd_x_base + j*s, line x = p + rd_x_off.
REQ-024 Lane j of rd_data SHALL be bank[rsel][rd_ch][x][rd_y] when p <= xlim, x < LINES, rd_ch < CH and rd_y < DEPTH; otherwise lane j SHALL be 0.
REQ-025 Read latency SHALL be exactly 1 cycle: rd_data and rd_data_valid are registered; rd_data_valid=1 for one cycle per accepted request.
REQ-026 rd_req while !rd_req_ready SHALL produce rd_data_valid=0 and rd_data=0 next cycle, and SHALL set err_rd.
REQ-027 Reads and writes SHALL be fully concurrent, with one request each per cycle and no bubbles.
REQ-028 rd_frame_done in the same cycle as an accepted rd_req SHALL still return that request's data.
REQ-029 bank_full[b] SHALL reflect bank b state (1=FULL).
REQ-030 err_wr and err_rd SHALL clear only on reset.

Reset
REQ-031 rst asserted SHALL immediately set: both banks EMPTY, wsel=rsel=0, rd_data=0, rd_data_valid=0, err_wr=err_rd=0; hence wr_ready=1, rd_req_ready=0, bank_full=0.
REQ-032 Memory contents SHALL NOT be reset; after reset they SHALL be unreachable until rewritten and marked FULL.
REQ-033 rst mid-operation SHALL drop any in-flight read response, so no rd_data_valid appears in the cycle after release.

Verification
REQ-034 Reset, then rd_req=1 -> rd_req_ready=0, next cycle rd_data_valid=0, err_rd=1; wr_ready=1.
REQ-035 Write ch0..7 base 0, x=0..31, y=0, data=ch*32+x (CH=6, so lanes 6,7 dropped), pulse wr_frame_done -> bank_full=01, wsel=1; rd_req ch2, base 0, off 0, STRIDE=1, INFMAP_ROWS=32, KERNEL_DIM=5 -> next cycle lanes 64..71, valid=1.
REQ-036 Same bank, STRIDE=2, base 20, off 1, KERNEL_DIM=5 -> p=20,22,24,26,28..; lanes 0-3 = ch2 lines 21,23,25,27; lanes 4-7 = 0 (p>27).
REQ-037 Fill both banks, then wr_valid -> wr_ready=0, no write, err_wr=1; rd_frame_done and wr_frame_done in one cycle -> bank0 EMPTY, err_wr set by the ignored wr_frame_done, rsel=1.
REQ-038 Assert rst during an accepted rd_req -> rd_data_valid=0 next cycle, bank_full=00, wr_ready=1.
REQ-039 Back-to-back rd_req over 32 cycles concurrent with writes to the other bank -> 32 valid responses, each exactly 1 cycle after its request, with no corruption of the read bank.

Source files
------------

// File: rtl/ofmap_pingpong_buf.sv
// Output-feature-map ping-pong buffer.
// Two banks of CH x LINES x DEPTH elements. The writer fills one bank while the
// reader drains the other; frame-done pulses hand a bank across. Reads gather
// ROWS lines of one channel along a strided window and return them one cycle later.
module ofmap_pingpong_buf #(
    parameter int DW      = 8,
    parameter int CH      = 6,
    parameter int LINES   = 32,
    parameter int DEPTH   = 32,
    parameter int COLS    = 8,
    parameter int ROWS    = 8,
    parameter int ADDR_DW = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            STRIDE,
    input  logic [3:0]            KERNEL_DIM,
    input  logic [5:0]            INFMAP_ROWS,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [3:0]            wr_ch_base,
    input  logic [ADDR_DW-1:0]    wr_x,
    input  logic [ADDR_DW-1:0]    wr_y,
    input  logic [DW*COLS-1:0]    wr_data,
    input  logic                  wr_frame_done,
    input  logic                  rd_req,
    output logic                  rd_req_ready,
    input  logic [3:0]            rd_ch,
    input  logic [ADDR_DW-1:0]    rd_x_base,
    input  logic [7:0]            rd_x_off,
    input  logic [ADDR_DW-1:0]    rd_y,
    output logic [DW*ROWS-1:0]    rd_data,
    output logic                  rd_data_valid,
    input  logic                  rd_frame_done,
    output logic [1:0]            bank_full,
    output logic                  err_wr,
    output logic                  err_rd
);

    localparam int BANK_WORDS = CH * LINES * DEPTH;
    localparam int MEM_WORDS  = 2 * BANK_WORDS;
    localparam int MEM_AW     = $clog2(MEM_WORDS);

    logic [DW-1:0]     mem [MEM_WORDS];
    logic              wsel, rsel;
    logic              wsel_nxt, rsel_nxt;
    logic [1:0]        bank_full_nxt;
    logic              wr_err_evt, rd_err_evt;
    logic              wr_fire, rd_fire;
    logic [COLS-1:0]   wr_lane_en;
    logic [MEM_AW-1:0] wr_addr [COLS];
    logic [ROWS-1:0]   rd_lane_hit;
    logic [MEM_AW-1:0] rd_addr [ROWS];
    int                stride_eff;
    int                xlim;

    // Flat word address; all arithmetic is done in 32-bit ints so nothing wraps.
    function automatic logic [MEM_AW-1:0] word_addr(input logic bank, input int ch,
                                                    input int x, input int y);
        return MEM_AW'(((int'(bank) * CH + ch) * LINES + x) * DEPTH + y);
    endfunction

    assign wr_ready     = ~bank_full[wsel];
    assign rd_req_ready = bank_full[rsel];
    assign wr_fire      = wr_valid & wr_ready;
    assign rd_fire      = rd_req & rd_req_ready;

    // A stride of 0 behaves as 1; a kernel larger than the map clamps the window to 0.
    assign stride_eff = (STRIDE == 2'd0) ? 1 : int'(STRIDE);
    assign xlim       = (int'(INFMAP_ROWS) >= int'(KERNEL_DIM)) ?
                        int'(INFMAP_ROWS) - int'(KERNEL_DIM) : 0;

    // Write lane decode: lanes mapping past the last channel are dropped.
    always_comb begin
        wr_lane_en = '0;
        for (int k = 0; k < COLS; k++) begin
            wr_lane_en[k] = wr_fire && (int'(wr_ch_base) + k < CH) &&
                            (int'(wr_x) < LINES) && (int'(wr_y) < DEPTH);
            wr_addr[k]    = wr_lane_en[k] ?
                            word_addr(wsel, int'(wr_ch_base) + k, int'(wr_x), int'(wr_y)) : '0;
        end
    end

    // Read lane decode: lane j looks at position base + j*stride shifted by the offset.
    always_comb begin
        rd_lane_hit = '0;
        for (int j = 0; j < ROWS; j++) begin
            rd_lane_hit[j] = (int'(rd_x_base) + j * stride_eff <= xlim) &&
                             (int'(rd_x_base) + j * stride_eff + int'(rd_x_off) < LINES) &&
                             (int'(rd_ch) < CH) && (int'(rd_y) < DEPTH);
            rd_addr[j]     = rd_lane_hit[j] ?
                             word_addr(rsel, int'(rd_ch),
                                       int'(rd_x_base) + j * stride_eff + int'(rd_x_off),
                                       int'(rd_y)) : '0;
        end
    end

    // Bank hand-over: both done pulses may act in the same cycle on different banks.
    always_comb begin
        bank_full_nxt = bank_full;
        wsel_nxt      = wsel;
        rsel_nxt      = rsel;
        wr_err_evt    = wr_valid & ~wr_ready;
        rd_err_evt    = rd_req & ~rd_req_ready;
        if (wr_frame_done) begin
            if (!bank_full[wsel]) begin
                bank_full_nxt[wsel] = 1'b1;
                wsel_nxt            = ~wsel;
            end else begin
                wr_err_evt = 1'b1;
            end
        end
        if (rd_frame_done) begin
            if (bank_full[rsel]) begin
                bank_full_nxt[rsel] = 1'b0;
                rsel_nxt            = ~rsel;
            end else begin
                rd_err_evt = 1'b1;
            end
        end
    end

    // Bank state, pointers and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_full <= 2'b00;
            wsel      <= 1'b0;
            rsel      <= 1'b0;
            err_wr    <= 1'b0;
            err_rd    <= 1'b0;
        end else begin
            bank_full <= bank_full_nxt;
            wsel      <= wsel_nxt;
            rsel      <= rsel_nxt;
            err_wr    <= err_wr | wr_err_evt;
            err_rd    <= err_rd | rd_err_evt;
        end
    end

    // Storage array is never reset; stale contents sit behind an EMPTY bank.
    always_ff @(posedge clk) begin
        for (int k = 0; k < COLS; k++) begin
            if (wr_lane_en[k]) begin
                mem[wr_addr[k]] <= wr_data[k*DW +: DW];
            end
        end
    end

    // Registered read response; zero whenever no request was accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data       <= '0;
            rd_data_valid <= 1'b0;
        end else begin
            rd_data_valid <= rd_fire;
            for (int j = 0; j < ROWS; j++) begin
                rd_data[j*DW +: DW] <= (rd_fire && rd_lane_hit[j]) ? mem[rd_addr[j]] : '0;
            end
        end
    end

endmodule

// File: tb/tb_ofmap_pingpong_buf.sv
// Testbench for ofmap_pingpong_buf: table of read vectors against a known bank
// image, plus hand-written sequences for bank hand-over, errors and reset.
module tb_ofmap_pingpong_buf;

    localparam int DW = 8, CH = 6, LINES = 32, DEPTH = 32, COLS = 8, ROWS = 8, ADDR_DW = 5;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [1:0]           STRIDE;
    logic [3:0]           KERNEL_DIM;
    logic [5:0]           INFMAP_ROWS;
    logic                 wr_valid, wr_ready, wr_frame_done;
    logic [3:0]           wr_ch_base;
    logic [ADDR_DW-1:0]   wr_x, wr_y;
    logic [DW*COLS-1:0]   wr_data;
    logic                 rd_req, rd_req_ready, rd_frame_done;
    logic [3:0]           rd_ch;
    logic [ADDR_DW-1:0]   rd_x_base, rd_y;
    logic [7:0]           rd_x_off;
    logic [DW*ROWS-1:0]   rd_data;
    logic                 rd_data_valid;
    logic [1:0]           bank_full;
    logic                 err_wr, err_rd;

    ofmap_pingpong_buf #(.DW(DW), .CH(CH), .LINES(LINES), .DEPTH(DEPTH), .COLS(COLS),
                         .ROWS(ROWS), .ADDR_DW(ADDR_DW)) dut (
        .clk(clk), .rst(rst), .STRIDE(STRIDE), .KERNEL_DIM(KERNEL_DIM),
        .INFMAP_ROWS(INFMAP_ROWS), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_ch_base(wr_ch_base), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
        .wr_frame_done(wr_frame_done), .rd_req(rd_req), .rd_req_ready(rd_req_ready),
        .rd_ch(rd_ch), .rd_x_base(rd_x_base), .rd_x_off(rd_x_off), .rd_y(rd_y),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_frame_done(rd_frame_done),
        .bank_full(bank_full), .err_wr(err_wr), .err_rd(err_rd));

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [63:0] d;
    } rsp_t;

    typedef struct packed {
        logic [3:0]  ch;
        logic [4:0]  xb;
        logic [7:0]  xo;
        logic [1:0]  st;
        logic [3:0]  kd;
        logic [5:0]  ir;
        logic [63:0] exp_d;
    } vec_t;

    logic [7:0] m_mem [2][CH][LINES][DEPTH];
    logic [1:0] m_full;
    bit         m_wsel, m_rsel;
    logic       m_err_wr, m_err_rd;
    rsp_t       sb[$];
    vec_t       tbl [9];
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic logic [63:0] lanes8(input int a0, input int a1, input int a2, input int a3,
                                           input int a4, input int a5, input int a6, input int a7);
        return {8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    // Reference gather from the model memory using the currently driven read inputs.
    function automatic logic [63:0] m_read();
        int s, xl, p, x;
        logic [63:0] r;
        r  = '0;
        s  = (STRIDE == 2'd0) ? 1 : int'(STRIDE);
        xl = int'(INFMAP_ROWS) - int'(KERNEL_DIM);
        if (xl < 0) xl = 0;
        for (int j = 0; j < ROWS; j++) begin
            p = int'(rd_x_base) + j * s;
            x = p + int'(rd_x_off);
            if (p <= xl && x < LINES && int'(rd_ch) < CH && int'(rd_y) < DEPTH)
                r[j*8 +: 8] = m_mem[m_rsel][int'(rd_ch)][x][int'(rd_y)];
        end
        return r;
    endfunction

    task automatic idle();
        wr_valid = 1'b0; wr_frame_done = 1'b0; rd_req = 1'b0; rd_frame_done = 1'b0;
    endtask

    task automatic set_wr(input bit v, input int base, input int x, input int y, input int tag);
        wr_valid   = v;
        wr_ch_base = 4'(base);
        wr_x       = 5'(x);
        wr_y       = 5'(y);
        for (int k = 0; k < COLS; k++) wr_data[k*8 +: 8] = 8'((base + k) * 32 + x + tag);
    endtask

    task automatic set_rd(input bit req, input int ch, input int xb, input int xo,
                          input int st, input int kd, input int ir, input int y);
        rd_req = req; rd_ch = 4'(ch); rd_x_base = 5'(xb); rd_x_off = 8'(xo);
        STRIDE = 2'(st); KERNEL_DIM = 4'(kd); INFMAP_ROWS = 6'(ir); rd_y = 5'(y);
    endtask

    task automatic model_reset();
        m_full = 2'b00; m_wsel = 1'b0; m_rsel = 1'b0; m_err_wr = 1'b0; m_err_rd = 1'b0;
        sb.delete();
    endtask

    // One clock: predict the response and next state, advance, then compare.
    task automatic tick(input string tag, input bit use_tbl, input logic [63:0] tbl_d);
        rsp_t       e;
        logic [1:0] nf;
        bit         nw, nr;
        e.v = 1'b0;
        e.d = '0;
        if (rd_req) begin
            if (m_full[m_rsel]) begin
                e.v = 1'b1;
                e.d = use_tbl ? tbl_d : m_read();
            end else begin
                m_err_rd = 1'b1;
            end
        end
        sb.push_back(e);
        if (wr_valid) begin
            if (!m_full[m_wsel]) begin
                for (int k = 0; k < COLS; k++)
                    if (int'(wr_ch_base) + k < CH)
                        m_mem[m_wsel][int'(wr_ch_base) + k][int'(wr_x)][int'(wr_y)] = wr_data[k*8 +: 8];
            end else begin
                m_err_wr = 1'b1;
            end
        end
        nf = m_full; nw = m_wsel; nr = m_rsel;
        if (wr_frame_done) begin
            if (!m_full[m_wsel]) begin nf[m_wsel] = 1'b1; nw = ~m_wsel; end
            else m_err_wr = 1'b1;
        end
        if (rd_frame_done) begin
            if (m_full[m_rsel]) begin nf[m_rsel] = 1'b0; nr = ~m_rsel; end
            else m_err_rd = 1'b1;
        end
        m_full = nf; m_wsel = nw; m_rsel = nr;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, " rd_data_valid"}, rd_data_valid, e.v);
        chk({tag, " rd_data"}, rd_data, e.d);
        chk({tag, " bank_full"}, bank_full, m_full);
        chk({tag, " err_wr"}, err_wr, m_err_wr);
        chk({tag, " err_rd"}, err_rd, m_err_rd);
        chk({tag, " wr_ready"}, wr_ready, !m_full[m_wsel]);
        chk({tag, " rd_req_ready"}, rd_req_ready, m_full[m_rsel]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Read vectors against bank 0 holding ch*32+x at y=0.
        tbl[0] = '{4'd2, 5'd0,  8'd0,   2'd1, 4'd5, 6'd32, lanes8(64, 65, 66, 67, 68, 69, 70, 71)};
        tbl[1] = '{4'd2, 5'd20, 8'd1,   2'd2, 4'd5, 6'd32, lanes8(85, 87, 89, 91, 0, 0, 0, 0)};
        tbl[2] = '{4'd0, 5'd3,  8'd0,   2'd0, 4'd5, 6'd32, lanes8(3, 4, 5, 6, 7, 8, 9, 10)};
        tbl[3] = '{4'd6, 5'd0,  8'd0,   2'd1, 4'd5, 6'd32, lanes8(0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[4] = '{4'd1, 5'd0,  8'd30,  2'd1, 4'd5, 6'd32, lanes8(62, 63, 0, 0, 0, 0, 0, 0)};
        tbl[5] = '{4'd3, 5'd0,  8'd5,   2'd3, 4'd9, 6'd4,  lanes8(101, 0, 0, 0, 0, 0, 0, 0)};
        tbl[6] = '{4'd4, 5'd0,  8'd255, 2'd1, 4'd5, 6'd32, lanes8(0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[7] = '{4'd5, 5'd1,  8'd2,   2'd3, 4'd1, 6'd32, lanes8(163, 166, 169, 172, 175, 178, 181, 184)};
        tbl[8] = '{4'd1, 5'd27, 8'd0,   2'd1, 4'd5, 6'd32, lanes8(59, 0, 0, 0, 0, 0, 0, 0)};

        for (int b = 0; b < 2; b++)
            for (int c = 0; c < CH; c++)
                for (int x = 0; x < LINES; x++)
                    for (int y = 0; y < DEPTH; y++) m_mem[b][c][x][y] = 8'h00;

        rst = 1'b1;
        idle();
        set_wr(0, 0, 0, 0, 0);
        set_rd(0, 0, 0, 0, 1, 5, 32, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset bank_full", bank_full, 2'b00);
        chk("reset wr_ready", wr_ready, 1'b1);
        chk("reset rd_req_ready", rd_req_ready, 1'b0);
        chk("reset rd_data_valid", rd_data_valid, 1'b0);
        chk("reset rd_data", rd_data, 64'h0);
        chk("reset err_wr", err_wr, 1'b0);
        chk("reset err_rd", err_rd, 1'b0);
        rst = 1'b0;
        model_reset();

        // Read with nothing full.
        set_rd(1, 0, 0, 0, 1, 5, 32, 0);
        tick("rd_empty", 0, '0);
        chk("rd_empty err_rd", err_rd, 1'b1);
        rd_req = 1'b0;

        // Fill bank 0 with ch*32+x; lanes 6,7 have no channel.
        for (int x = 0; x < LINES; x++) begin
            set_wr(1, 0, x, 0, 0);
            tick("fill0", 0, '0);
        end
        idle();
        wr_frame_done = 1'b1;
        tick("fill0_done", 0, '0);
        wr_frame_done = 1'b0;
        chk("fill0 bank_full", bank_full, 2'b01);

        for (int i = 0; i < 9; i++) begin
            set_rd(1, int'(tbl[i].ch), int'(tbl[i].xb), int'(tbl[i].xo), int'(tbl[i].st),
                   int'(tbl[i].kd), int'(tbl[i].ir), 0);
            tick($sformatf("tbl%0d", i), 1, tbl[i].exp_d);
        end
        idle();
        tick("tbl_idle", 0, '0);

        // Back-to-back reads of bank 0 while bank 1 is written.
        for (int i = 0; i < 32; i++) begin
            set_wr(1, 0, i, 0, 77);
            set_rd(1, int'($urandom_range(0, 7)), int'($urandom_range(0, 31)),
                   int'($urandom_range(0, 40)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 15)), int'($urandom_range(0, 63)), 0);
            tick($sformatf("b2b%0d", i), 0, '0);
        end
        idle();
        tick("b2b_idle", 0, '0);
        wr_frame_done = 1'b1;
        tick("fill1_done", 0, '0);
        wr_frame_done = 1'b0;
        chk("both full bank_full", bank_full, 2'b11);

        // Both done pulses together: write side ignored, read side releases bank 0.
        wr_frame_done = 1'b1;
        rd_frame_done = 1'b1;
        tick("both_done", 0, '0);
        idle();
        chk("both_done bank_full", bank_full, 2'b10);
        chk("both_done err_wr", err_wr, 1'b1);

        set_rd(1, 0, 0, 0, 1, 5, 32, 0);
        tick("bank1_ch0", 0, '0);
        chk("bank1_ch0 const", rd_data, lanes8(77, 78, 79, 80, 81, 82, 83, 84));
        for (int i = 0; i < 6; i++) begin
            set_rd(1, int'($urandom_range(0, 7)), int'($urandom_range(0, 31)),
                   int'($urandom_range(0, 20)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 15)), int'($urandom_range(0, 63)), 0);
            tick($sformatf("bank1_rd%0d", i), 0, '0);
        end

        // Reset while a request is accepted.
        set_rd(1, 2, 0, 0, 1, 5, 32, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst bank_full", bank_full, 2'b00);
        chk("mid_rst wr_ready", wr_ready, 1'b1);
        chk("mid_rst rd_req_ready", rd_req_ready, 1'b0);
        chk("mid_rst rd_data_valid", rd_data_valid, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        model_reset();
        @(posedge clk);
        #1;
        chk("post_rst rd_data_valid", rd_data_valid, 1'b0);
        chk("post_rst err_rd", err_rd, 1'b0);

        rd_frame_done = 1'b1;
        tick("rd_done_empty", 0, '0);
        rd_frame_done = 1'b0;
        chk("rd_done_empty err_rd", err_rd, 1'b1);

        // Refill bank 0 from channel base 3; the last write shares a cycle with wr_frame_done.
        for (int x = 0; x < LINES; x++) begin
            set_wr(1, 3, x, 0, 20);
            wr_frame_done = (x == LINES - 1);
            tick("refill0", 0, '0);
        end
        idle();
        wr_frame_done = 1'b1;
        tick("empty_frame1", 0, '0);
        idle();

        set_wr(1, 0, 0, 0, 100);
        tick("wr_full", 0, '0);
        idle();
        chk("wr_full err_wr", err_wr, 1'b1);

        set_rd(1, 0, 0, 0, 1, 5, 32, 0);
        tick("refill_ch0", 0, '0);
        chk("refill_ch0 const", rd_data, lanes8(0, 1, 2, 3, 4, 5, 6, 7));
        set_rd(1, 3, 0, 0, 1, 5, 32, 0);
        tick("refill_ch3", 0, '0);
        chk("refill_ch3 const", rd_data, lanes8(116, 117, 118, 119, 120, 121, 122, 123));
        set_rd(1, 5, 31, 0, 1, 5, 32, 0);
        tick("refill_x31", 0, '0);
        set_rd(1, 5, 24, 0, 1, 5, 32, 0);
        rd_frame_done = 1'b1;
        tick("rd_with_done", 0, '0);
        chk("rd_with_done const", rd_data, lanes8(204, 205, 206, 207, 0, 0, 0, 0));
        chk("rd_with_done bank_full", bank_full, 2'b10);
        idle();
        tick("final_idle", 0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
